seg_disp_sched: RTL and testbench



---
 rtl/seg_disp_sched.sv | 210 +++++++++++++++++++++
 tb/tb_seg_disp_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_sched.sv
// Time-shares the 6-digit 7-segment driver between three status pages,
// with timed rotation, blank gaps and a retriggerable threshold override.
module seg_disp_sched #(
  parameter int TICK_DIV = 50000,
  parameter int PAGE_MS  = 2000,
  parameter int BLANK_MS = 100,
  parameter int HOLD_MS  = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  src_vld,
  input  logic [59:0] src_data,
  input  logic [17:0] src_point,
  input  logic [2:0]  src_sign,
  input  logic        ovr_req,
  input  logic        freeze,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        en,
  output logic [1:0]  page,
  output logic        ovr_act
);

  localparam int          TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0] PAGE_LAST  = 16'(PAGE_MS - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_MS - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_MS - 1);
  localparam logic [19:0] DATA_MAX   = 20'd999999;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK, OVR} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   ms_cnt_q, ms_cnt_d;
  logic [1:0]    page_q, page_d;
  logic [1:0]    saved_q, saved_d;
  logic [19:0]   data_q, data_d;
  logic [5:0]    point_q, point_d;
  logic          sign_q, sign_d;
  logic          en_q, en_d;
  logic          ovr_act_q, ovr_act_d;

  logic          tick;
  logic          ovr_go;
  logic [1:0]    cand1, cand2, nxt_page, low_page;
  logic          nxt_found;
  logic [19:0]   raw_data;
  logic [5:0]    raw_point;
  logic          raw_sign;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Round-robin successor of the current page: page+1, page+2, then page itself.
  always_comb begin
    cand1     = (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;
    cand2     = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    nxt_found = 1'b1;
    if (src_vld[cand1])       nxt_page = cand1;
    else if (src_vld[cand2])  nxt_page = cand2;
    else if (src_vld[page_q]) nxt_page = page_q;
    else begin
      nxt_page  = page_q;
      nxt_found = 1'b0;
    end
    if (src_vld[0])      low_page = 2'd0;
    else if (src_vld[1]) low_page = 2'd1;
    else                 low_page = 2'd2;
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    saved_d  = saved_q;
    ms_cnt_d = ms_cnt_q;
    ovr_go   = ovr_req & src_vld[0];
    case (state_q)
      IDLE: begin
        if (ovr_go) begin
          state_d  = OVR;
          saved_d  = nxt_page;
          page_d   = 2'd0;
          ms_cnt_d = '0;
        end else if (|src_vld) begin
          state_d  = SHOW;
          page_d   = low_page;
          ms_cnt_d = '0;
        end
      end
      SHOW: begin
        if (ovr_go) begin
          state_d  = OVR;
          saved_d  = page_q;
          page_d   = 2'd0;
          ms_cnt_d = '0;
        end else if (!src_vld[page_q]) begin
          state_d  = BLANK;
          ms_cnt_d = '0;
        end else if (tick && !freeze) begin
          if (ms_cnt_q == PAGE_LAST) begin
            state_d  = BLANK;
            ms_cnt_d = '0;
          end else begin
            ms_cnt_d = ms_cnt_q + 16'd1;
          end
        end
      end
      BLANK: begin
        if (ovr_go) begin
          state_d  = OVR;
          saved_d  = nxt_page;
          page_d   = 2'd0;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_cnt_q == BLANK_LAST) begin
            ms_cnt_d = '0;
            state_d  = nxt_found ? SHOW : IDLE;
            page_d   = nxt_page;
          end else begin
            ms_cnt_d = ms_cnt_q + 16'd1;
          end
        end
      end
      OVR: begin
        // Leaving via BLANK with page=saved lets the next-page rule start from it.
        if (ovr_go) begin
          ms_cnt_d = '0;
        end else if (!src_vld[0] || (tick && ms_cnt_q == HOLD_LAST)) begin
          ms_cnt_d = '0;
          page_d   = saved_q;
          state_d  = src_vld[saved_q] ? SHOW : BLANK;
        end else if (tick) begin
          ms_cnt_d = ms_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        ms_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    en_d      = (state_d == SHOW) || (state_d == OVR);
    ovr_act_d = (state_d == OVR);
    case (page_d)
      2'd0: begin
        raw_data  = src_data[19:0];
        raw_point = src_point[5:0];
        raw_sign  = src_sign[0];
      end
      2'd1: begin
        raw_data  = src_data[39:20];
        raw_point = src_point[11:6];
        raw_sign  = src_sign[1];
      end
      default: begin
        raw_data  = src_data[59:40];
        raw_point = src_point[17:12];
        raw_sign  = src_sign[2];
      end
    endcase
    data_d  = '0;
    point_d = '0;
    sign_d  = 1'b0;
    if (en_d) begin
      data_d  = (raw_data > DATA_MAX) ? DATA_MAX : raw_data;
      point_d = raw_point;
      sign_d  = raw_sign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      ms_cnt_q   <= '0;
      page_q     <= '0;
      saved_q    <= '0;
      data_q     <= '0;
      point_q    <= '0;
      sign_q     <= 1'b0;
      en_q       <= 1'b0;
      ovr_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      page_q     <= page_d;
      saved_q    <= saved_d;
      data_q     <= data_d;
      point_q    <= point_d;
      sign_q     <= sign_d;
      en_q       <= en_d;
      ovr_act_q  <= ovr_act_d;
    end
  end

  assign data    = data_q;
  assign point   = point_q;
  assign sign    = sign_q;
  assign en      = en_q;
  assign page    = page_q;
  assign ovr_act = ovr_act_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched: directed scenarios plus random traffic,
// compared every cycle against a countdown-based behavioural model.
module tb_seg_disp_sched;

  localparam int TICK_DIV = 10;
  localparam int PAGE_MS  = 4;
  localparam int BLANK_MS = 2;
  localparam int HOLD_MS  = 6;

  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_BLANK = 2;
  localparam int M_OVR   = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  src_vld;
  logic [59:0] src_data;
  logic [17:0] src_point;
  logic [2:0]  src_sign;
  logic        ovr_req;
  logic        freeze;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        en;
  logic [1:0]  page;
  logic        ovr_act;

  int total;
  int bad;

  int m_mode, m_page, m_saved, m_left, m_phase;
  logic [19:0] exp_data;
  logic [5:0]  exp_point;
  logic        exp_sign, exp_en, exp_ovr;
  logic [1:0]  exp_page;

  seg_disp_sched #(
    .TICK_DIV(TICK_DIV), .PAGE_MS(PAGE_MS), .BLANK_MS(BLANK_MS), .HOLD_MS(HOLD_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_data(src_data),
    .src_point(src_point), .src_sign(src_sign), .ovr_req(ovr_req), .freeze(freeze),
    .data(data), .point(point), .sign(sign), .en(en), .page(page), .ovr_act(ovr_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // First valid page after p in rotation order (p+1, p+2, p); -1 when none.
  function automatic int next_valid(input int p);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (p + k) % 3;
      if (src_vld[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_page = 0; m_saved = 0; m_left = 0; m_phase = 0;
    exp_data = '0; exp_point = '0; exp_sign = 0; exp_en = 0; exp_ovr = 0; exp_page = '0;
  endtask

  task automatic show_page(input int p);
    m_mode = M_SHOW; m_page = p; m_left = PAGE_MS;
  endtask

  task automatic start_blank();
    m_mode = M_BLANK; m_left = BLANK_MS;
  endtask

  task automatic enter_ovr(input int s);
    m_mode = M_OVR; m_saved = s; m_left = HOLD_MS;
  endtask

  task automatic leave_ovr();
    m_page = m_saved;
    if (src_vld[m_saved]) show_page(m_saved);
    else start_blank();
  endtask

  task automatic model_edge();
    bit tick, ovr;
    int p, raw;
    tick    = (m_phase == TICK_DIV - 1);
    m_phase = tick ? 0 : m_phase + 1;
    ovr     = ovr_req && src_vld[0];
    case (m_mode)
      M_IDLE: begin
        if (ovr) enter_ovr(next_valid(m_page));
        else if (src_vld != 0) show_page(next_valid(2));
      end
      M_SHOW: begin
        if (ovr) enter_ovr(m_page);
        else if (!src_vld[m_page]) start_blank();
        else if (tick && !freeze) begin
          m_left--;
          if (m_left == 0) start_blank();
        end
      end
      M_BLANK: begin
        if (ovr) enter_ovr(next_valid(m_page));
        else if (tick) begin
          m_left--;
          if (m_left == 0) begin
            p = next_valid(m_page);
            if (p < 0) m_mode = M_IDLE;
            else show_page(p);
          end
        end
      end
      default: begin
        if (ovr) m_left = HOLD_MS;
        else if (!src_vld[0]) leave_ovr();
        else if (tick) begin
          m_left--;
          if (m_left == 0) leave_ovr();
        end
      end
    endcase
    exp_en   = (m_mode == M_SHOW) || (m_mode == M_OVR);
    exp_ovr  = (m_mode == M_OVR);
    exp_page = (m_mode == M_OVR) ? 2'd0 : 2'(m_page);
    exp_data = '0; exp_point = '0; exp_sign = 0;
    if (exp_en) begin
      p         = int'(exp_page);
      raw       = int'(src_data[p*20 +: 20]);
      exp_data  = (raw > 999999) ? 20'd999999 : 20'(raw);
      exp_point = src_point[p*6 +: 6];
      exp_sign  = src_sign[p];
    end
  endtask

  task automatic check_outputs();
    check("en", 32'(en), 32'(exp_en));
    check("ovr_act", 32'(ovr_act), 32'(exp_ovr));
    check("page", 32'(page), 32'(exp_page));
    check("data", 32'(data), 32'(exp_data));
    check("point", 32'(point), 32'(exp_point));
    check("sign", 32'(sign), 32'(exp_sign));
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic run_until(input string tag, input int mode, input int pg, input int budget);
    int n;
    n = 0;
    while (!(m_mode == mode && (pg < 0 || m_page == pg)) && n < budget) begin
      run_cycles(1);
      n++;
    end
    total++;
    assert (n < budget) else begin
      bad++;
      $error("FAIL %s timeout observed=%0d expected=<%0d cycles", tag, n, budget);
    end
  endtask

  task automatic pulse_ovr();
    ovr_req = 1'b1;
    run_cycles(1);
    ovr_req = 1'b0;
  endtask

  task automatic set_page(input int p, input logic [19:0] v);
    src_data[p*20 +: 20] = v;
  endtask

  initial begin
    int cnt;
    total = 0; bad = 0;
    rst_n = 1'b0; src_vld = '0; src_data = '0; src_point = '0; src_sign = '0;
    ovr_req = 1'b0; freeze = 1'b0;
    model_reset();
    #1;
    check_outputs();
    run_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] rotation");
    set_page(0, 20'd123); set_page(1, 20'd60); set_page(2, 20'd999);
    src_point = 18'($urandom); src_sign = 3'b000;
    src_vld = 3'b111;
    run_until("rot_p1", M_SHOW, 1, 200);
    cnt = 1;
    while (en === 1'b1 && cnt < 100) begin run_cycles(1); cnt++; end
    check("show_len", 32'(cnt - 1), 32'(PAGE_MS * TICK_DIV));
    cnt = 0;
    while (en === 1'b0 && cnt < 100) begin run_cycles(1); cnt++; end
    check("blank_len", 32'(cnt), 32'(BLANK_MS * TICK_DIV));
    check("rot_page2", 32'(page), 32'd2);
    run_until("rot_p0", M_SHOW, 0, 200);

    $display("[TB] skip and wrap");
    src_vld = 3'b101;
    run_until("skip_p2", M_SHOW, 2, 200);
    run_until("skip_p0", M_SHOW, 0, 200);
    run_until("skip_p2b", M_SHOW, 2, 200);
    run_cycles(5);
    src_vld = 3'b001;
    run_cycles(1);
    check("drop_en", 32'(en), 32'd0);
    run_until("drop_p0", M_SHOW, 0, 200);
    src_vld = 3'b000;
    run_until("idle", M_IDLE, -1, 200);
    run_cycles(3);

    $display("[TB] override");
    set_page(0, 20'($urandom_range(0, 999999)));
    set_page(2, 20'($urandom_range(0, 999999)));
    src_vld = 3'b111;
    run_until("ovr_p2", M_SHOW, 2, 300);
    run_cycles(7);
    pulse_ovr();
    check("ovr_act", 32'(ovr_act), 32'd1);
    check("ovr_page", 32'(page), 32'd0);
    run_cycles(29);
    pulse_ovr();
    cnt = 1;
    while (ovr_act === 1'b1 && cnt < 100) begin run_cycles(1); cnt++; end
    check("hold_max", 32'(cnt <= HOLD_MS * TICK_DIV), 32'd1);
    check("hold_min", 32'(cnt > (HOLD_MS - 1) * TICK_DIV), 32'd1);
    check("restore_p2", 32'(page), 32'd2);
    run_cycles(20);
    src_vld = 3'b110;
    pulse_ovr();
    check("ovr_ignored", 32'(ovr_act), 32'd0);
    run_cycles(10);

    $display("[TB] freeze and collision");
    src_vld = 3'b111;
    run_until("frz_show", M_SHOW, -1, 300);
    run_cycles(5);
    freeze = 1'b1;
    run_cycles(200);
    freeze = 1'b0;
    run_until("frz_blank", M_BLANK, -1, 100);
    run_until("col_show", M_SHOW, -1, 100);
    cnt = 0;
    while (!(m_mode == M_SHOW && m_left == 1 && m_phase == TICK_DIV - 1) && cnt < 100) begin
      run_cycles(1); cnt++;
    end
    pulse_ovr();
    check("collide_ovr", 32'(ovr_act), 32'd1);
    check("collide_en", 32'(en), 32'd1);
    run_until("col_exit", M_SHOW, -1, 200);

    $display("[TB] saturation, sign, reset");
    set_page(1, 20'hFFFFF);
    src_sign = 3'b010;
    src_point[11:6] = 6'b000100;
    run_until("sat_p1", M_SHOW, 1, 400);
    run_cycles(1);
    check("sat_data", 32'(data), 32'd999999);
    check("sat_sign", 32'(sign), 32'd1);
    check("sat_point", 32'(point), 32'd4);
    run_until("sat_blank", M_BLANK, -1, 100);
    check("blank_data", 32'(data), 32'd0);
    check("blank_sign", 32'(sign), 32'd0);
    run_until("rst_show", M_SHOW, -1, 100);
    run_cycles(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_en", 32'(en), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_page", 32'(page), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    model_reset();
    run_cycles(2);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) src_vld = 3'($urandom);
      if ($urandom_range(0, 9) == 0) src_data = {20'($urandom), 20'($urandom), 20'($urandom)};
      if ($urandom_range(0, 29) == 0) src_point = 18'($urandom);
      if ($urandom_range(0, 29) == 0) src_sign = 3'($urandom);
      if ($urandom_range(0, 99) == 0) freeze = ~freeze;
      ovr_req = ($urandom_range(0, 79) == 0);
      run_cycles(1);
    end
    ovr_req = 1'b0;
    freeze  = 1'b0;
    run_cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
